// File: rtl/pair_triple_detector_seq.sv
// Registered pair/triple/threshold detector with a hold/debounce FSM driving `stable`.
// Define PTD_EVENT_COUNT_EN to build the saturating counter of `stable` rising edges.
module pair_triple_detector_seq #(
  parameter int unsigned NBITS = 8,
  parameter int unsigned HOLD  = 2,
  parameter int unsigned CNT_W = 8,
  localparam int unsigned PW   = $clog2(NBITS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_val,
  input  logic [NBITS-1:0] in_bits,
  input  logic [PW-1:0]    thresh,
  input  logic             clr,
  output logic [PW-1:0]    popcnt,
  output logic             pair,
  output logic             triple,
  output logic             match,
  output logic             stable,
  output logic [CNT_W-1:0] event_count
);

  localparam int unsigned RW = $clog2(HOLD + 1);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StArm    = 2'd1,
    StStable = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [RW-1:0] run_q, run_d;
  logic [PW-1:0] popcnt_q, popcnt_d;
  logic          pair_q, pair_d;
  logic          triple_q, triple_d;
  logic          match_q, match_d;
  logic          stable_q, stable_d;

  logic [PW-1:0] pop_now;
  logic          match_now;

  always_comb begin
    pop_now = '0;
    for (int i = 0; i < int'(NBITS); i++) begin
      pop_now = pop_now + PW'(in_bits[i]);
    end
  end

  // Popcount never exceeds NBITS, so thresholds above NBITS never match.
  assign match_now = (pop_now >= thresh);

  always_comb begin
    popcnt_d = popcnt_q;
    pair_d   = pair_q;
    triple_d = triple_q;
    match_d  = match_q;
    if (in_val) begin
      popcnt_d = pop_now;
      pair_d   = (pop_now >= PW'(2));
      triple_d = (pop_now >= PW'(3));
      match_d  = match_now;
    end
  end

  // Gaps (in_val=0) leave state and run untouched, so a run survives idle cycles.
  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    if (in_val) begin
      unique case (state_q)
        StIdle: begin
          if (match_now) begin
            if (HOLD == 1) begin
              state_d = StStable;
            end else begin
              state_d = StArm;
              run_d   = RW'(1);
            end
          end
        end
        StArm: begin
          if (match_now) begin
            run_d = run_q + RW'(1);
            if (run_d == RW'(HOLD)) begin
              state_d = StStable;
            end
          end else begin
            state_d = StIdle;
            run_d   = '0;
          end
        end
        StStable: begin
          if (!match_now) begin
            state_d = StIdle;
            run_d   = '0;
          end
        end
        default: begin
          state_d = StIdle;
          run_d   = '0;
        end
      endcase
    end
  end

  assign stable_d = (state_d == StStable);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      run_q    <= '0;
      popcnt_q <= '0;
      pair_q   <= 1'b0;
      triple_q <= 1'b0;
      match_q  <= 1'b0;
      stable_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      run_q    <= run_d;
      popcnt_q <= popcnt_d;
      pair_q   <= pair_d;
      triple_q <= triple_d;
      match_q  <= match_d;
      stable_q <= stable_d;
    end
  end

  assign popcnt = popcnt_q;
  assign pair   = pair_q;
  assign triple = triple_q;
  assign match  = match_q;
  assign stable = stable_q;

`ifdef PTD_EVENT_COUNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             enter_stable;

  assign enter_stable = (state_q != StStable) && (state_d == StStable);

  // Clear takes priority over a concurrent increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (enter_stable && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign event_count = cnt_q;
`else
  logic unused_clr;
  assign unused_clr  = clr;
  assign event_count = '0;
`endif

endmodule

// File: tb/tb_pair_triple_detector_seq.sv
// Self-checking bench for pair_triple_detector_seq: directed scenarios plus a random run
// compared against a run-length reference model.
module tb_pair_triple_detector_seq;

  localparam int NBITS = 8;
  localparam int HOLD  = 2;
  localparam int CNT_W = 2;
  localparam int PW    = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_val = 1'b0;
  logic [NBITS-1:0] in_bits = '0;
  logic [PW-1:0]    thresh = '0;
  logic             clr = 1'b0;
  logic [PW-1:0]    popcnt;
  logic             pair, triple, match, stable;
  logic [CNT_W-1:0] event_count;

  int errors = 0;
  int checks = 0;

  // Reference model: consecutive valid matches since the last non-match or reset.
  int m_pop = 0, m_run = 0, m_ev = 0;
  bit m_pair = 0, m_triple = 0, m_match = 0, m_stable = 0;

  pair_triple_detector_seq #(
    .NBITS(NBITS),
    .HOLD (HOLD),
    .CNT_W(CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_val     (in_val),
    .in_bits    (in_bits),
    .thresh     (thresh),
    .clr        (clr),
    .popcnt     (popcnt),
    .pair       (pair),
    .triple     (triple),
    .match      (match),
    .stable     (stable),
    .event_count(event_count)
  );

  always #5 clk = ~clk;

  function automatic int exp_ev(input int n);
`ifdef PTD_EVENT_COUNT_EN
    return n;
`else
    return 0;
`endif
  endfunction

  task automatic step(input bit r, input bit v, input logic [NBITS-1:0] b,
                      input int t, input bit c);
    int  pc;
    bit  ns;
    rst = r; in_val = v; in_bits = b; thresh = PW'(t); clr = c;
    @(posedge clk);
    if (r) begin
      m_pop = 0; m_pair = 0; m_triple = 0; m_match = 0; m_stable = 0; m_run = 0; m_ev = 0;
    end else begin
      if (v) begin
        pc       = $countones(b);
        m_pop    = pc;
        m_pair   = (pc >= 2);
        m_triple = (pc >= 3);
        m_match  = (pc >= t);
        if (m_match) m_run = (m_run < HOLD) ? m_run + 1 : m_run;
        else m_run = 0;
        ns = (m_run >= HOLD);
        if (ns && !m_stable && m_ev < CMAX) m_ev++;
        m_stable = ns;
      end
      if (c) m_ev = 0;
      m_ev = exp_ev(m_ev);
    end
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      step(1, 1, 8'hFF, 0, 0);
      checks++;
      if ({popcnt, pair, triple, match, stable, event_count} !== '0) begin
        errors++;
        $display("FAIL reset[%0d]: got pop=%0d p=%0b t=%0b m=%0b s=%0b ev=%0d expected all 0",
                 i, popcnt, pair, triple, match, stable, event_count);
      end
    end
  endtask

  task automatic test_flags();
    logic [7:0] bits [5] = '{8'h00, 8'h01, 8'h03, 8'h07, 8'hFF};
    int         pcs  [5] = '{0, 1, 2, 3, 8};
    bit         prs  [5] = '{0, 0, 1, 1, 1};
    bit         trs  [5] = '{0, 0, 0, 1, 1};
    bit         mts  [5] = '{0, 0, 0, 0, 1};
    step(1, 0, 8'h00, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 1, bits[i], 4, 0);
      checks++;
      if (popcnt !== PW'(pcs[i]) || pair !== prs[i] || triple !== trs[i] || match !== mts[i])
      begin
        errors++;
        $display("FAIL flags[%0d]: got pop=%0d p=%0b t=%0b m=%0b expected pop=%0d p=%0b t=%0b m=%0b",
                 i, popcnt, pair, triple, match, pcs[i], prs[i], trs[i], mts[i]);
      end
    end
  endtask

  task automatic test_debounce();
    step(1, 0, 8'h00, 0, 0);
    step(0, 1, 8'h03, 2, 0);
    checks++;
    if (stable !== 1'b0 || match !== 1'b1) begin
      errors++; $display("FAIL debounce_first: got s=%0b m=%0b expected s=0 m=1", stable, match);
    end
    step(0, 0, 8'h00, 2, 0);
    checks++;
    if (stable !== 1'b0 || match !== 1'b1) begin
      errors++; $display("FAIL debounce_gap: got s=%0b m=%0b expected s=0 m=1", stable, match);
    end
    step(0, 1, 8'h03, 2, 0);
    checks++;
    if (stable !== 1'b1 || event_count !== CNT_W'(exp_ev(1))) begin
      errors++;
      $display("FAIL debounce_rise: got s=%0b ev=%0d expected s=1 ev=%0d",
               stable, event_count, exp_ev(1));
    end
    step(0, 1, 8'h01, 2, 0);
    checks++;
    if (stable !== 1'b0 || match !== 1'b0 || event_count !== CNT_W'(exp_ev(1))) begin
      errors++;
      $display("FAIL debounce_fall: got s=%0b m=%0b ev=%0d expected s=0 m=0 ev=%0d",
               stable, match, event_count, exp_ev(1));
    end
  endtask

  task automatic test_break_arm();
    logic [7:0] bits [4] = '{8'h03, 8'h01, 8'h03, 8'h03};
    bit         exps [4] = '{0, 0, 0, 1};
    step(1, 0, 8'h00, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, bits[i], 2, 0);
      checks++;
      if (stable !== exps[i]) begin
        errors++;
        $display("FAIL break_arm[%0d]: got s=%0b expected s=%0b", i, stable, exps[i]);
      end
    end
  endtask

  task automatic test_saturation();
    step(1, 0, 8'h00, 0, 0);
    for (int k = 1; k <= 5; k++) begin
      step(0, 1, 8'h03, 2, 0);
      step(0, 1, 8'h03, 2, 0);
      checks++;
      if (stable !== 1'b1 || event_count !== CNT_W'(exp_ev(k > 3 ? 3 : k))) begin
        errors++;
        $display("FAIL sat_rise[%0d]: got s=%0b ev=%0d expected s=1 ev=%0d",
                 k, stable, event_count, exp_ev(k > 3 ? 3 : k));
      end
      step(0, 1, 8'h01, 2, 0);
    end
    step(0, 1, 8'h03, 2, 0);
    step(0, 1, 8'h03, 2, 1);
    checks++;
    if (stable !== 1'b1 || event_count !== '0) begin
      errors++;
      $display("FAIL sat_clear: got s=%0b ev=%0d expected s=1 ev=0", stable, event_count);
    end
  endtask

  task automatic test_reset_midrun();
    step(1, 0, 8'h00, 0, 0);
    step(0, 1, 8'h07, 2, 0);
    step(0, 1, 8'h07, 2, 0);
    step(1, 1, 8'h07, 2, 0);
    checks++;
    if ({popcnt, pair, triple, match, stable, event_count} !== '0) begin
      errors++;
      $display("FAIL midrun_reset: got pop=%0d m=%0b s=%0b ev=%0d expected all 0",
               popcnt, match, stable, event_count);
    end
    step(0, 1, 8'h07, 2, 0);
    checks++;
    if (stable !== 1'b0 || match !== 1'b1 || popcnt !== PW'(3)) begin
      errors++;
      $display("FAIL midrun_after: got s=%0b m=%0b pop=%0d expected s=0 m=1 pop=3",
               stable, match, popcnt);
    end
  endtask

  task automatic test_random();
    logic [NBITS-1:0] b;
    int t;
    step(1, 0, 8'h00, 0, 0);
    for (int i = 0; i < 400; i++) begin
      b = NBITS'($urandom);
      if ($urandom_range(0, 1) == 1) b = b & NBITS'($urandom);
      t = ($urandom_range(0, 15) == 0) ? $urandom_range(9, 15) : $urandom_range(0, 5);
      step($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0, b, t,
           $urandom_range(0, 11) == 0);
      checks++;
      if (popcnt !== PW'(m_pop) || pair !== m_pair || triple !== m_triple ||
          match !== m_match || stable !== m_stable || event_count !== CNT_W'(m_ev)) begin
        errors++;
        $display("FAIL random[%0d]: got pop=%0d p=%0b t=%0b m=%0b s=%0b ev=%0d expected pop=%0d p=%0b t=%0b m=%0b s=%0b ev=%0d",
                 i, popcnt, pair, triple, match, stable, event_count,
                 m_pop, m_pair, m_triple, m_match, m_stable, m_ev);
      end
    end
  endtask

  initial begin
    test_reset();
    test_flags();
    test_debounce();
    test_break_arm();
    test_saturation();
    test_reset_midrun();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pair_triple_detector_seq.md
# pair_triple_detector_seq

Registered, parametrised successor to the combinational pair/triple detector. Accepts an NBITS-wide input word under a valid strobe, computes its population count, and flags pair (≥2 ones), triple (≥3 ones) and a runtime-threshold match. A hold/debounce FSM asserts `stable` only after HOLD consecutive valid matching samples. An optional saturating counter tallies `stable` rising edges. The block sits behind the TinyTapeout wrapper, driven from `ui_in`/`uio_in` and observed on `uo_out`.

## Interface
- `NBITS`, 8: input word width; ≥3.
- `HOLD`, 2: consecutive valid matching samples required for `stable`; ≥1.
- `CNT_W`, 8: event counter width; ≥1.
- PW denotes $clog2(NBITS+1).

- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_val`  in  1  input sample valid.
- `in_bits`  in  NBITS  sample word.
- `thresh`  in  PW  match threshold, unsigned; sampled together with `in_bits`.
- `clr`  in  1  synchronous clear of `event_count`.
- `popcnt`  out  PW  registered population count of last accepted sample.
- `pair`  out  1  registered: popcnt ≥ 2.
- `triple`  out  1  registered: popcnt ≥ 3.
- `match`  out  1  registered: popcnt ≥ thresh.
- `stable`  out  1  debounced match (FSM in STABLE).
- `event_count`  out  CNT_W  count of `stable` 0→1 transitions (only with macro).

## Operation
- Accept: edge where `in_val`=1. Popcount computed combinationally from `in_bits`, then `popcnt`/`pair`/`triple`/`match` registered.
- `in_val`=0: all registered outputs hold; FSM and run counter hold (gaps do not break a run).
- thresh=0: every valid sample matches. thresh>NBITS: never matches.
- FSM states IDLE, ARM, STABLE; run counter width $clog2(HOLD+1).
  - IDLE: valid∧match → STABLE if HOLD=1, else ARM with run=1. Otherwise stay.
  - ARM: valid∧match → run+1; if run+1=HOLD → STABLE. valid∧¬match → IDLE, run=0.
  - STABLE: valid∧¬match → IDLE, run=0. Otherwise stay.
- `stable` = (state==STABLE), registered.
- Match is evaluated on the incoming sample (same comparator that loads `match`), so `stable` and `match` are updated on the same edge.
- Event counter: +1 on edge where FSM enters STABLE from IDLE/ARM; saturates at 2^CNT_W−1; `clr` zeroes it; `clr` concurrent with increment → 0 (clear wins).

## Timing
- Reset: `popcnt`=0, `pair`=0, `triple`=0, `match`=0, `stable`=0, `event_count`=0, FSM=IDLE, run=0. `rst` overrides `in_val` and `clr`.
- Reset mid-run (ARM or STABLE): next edge returns to reset values; run not retained.
- Latency: sample accepted at edge N → flags visible after edge N (1 cycle).
- `stable` rises after edge of HOLD-th consecutive valid match; falls after edge of first valid non-match (same edge `match` falls).
- `event_count` reflects increment after the same edge `stable` rises.
- No backpressure; every valid cycle is accepted.

## Configuration
- `PTD_EVENT_COUNT_EN` defined: event counter and `clr` logic compiled in; `event_count` as specified.
- Undefined: counter omitted; `event_count` tied to 0; `clr` ignored. All other behaviour identical.

## Test plan
- Reset: hold `rst`=1 two cycles with `in_val`=1, `in_bits`=8'hFF → all outputs 0 after each edge.
- Flags, NBITS=8: valid 8'h00, 8'h01, 8'h03, 8'h07, 8'hFF with thresh=4 → popcnt 0,1,2,3,8; pair 0,0,1,1,1; triple 0,0,0,1,1; match 0,0,0,0,1, each one cycle after accept.
- Debounce, HOLD=2, thresh=2: valid 8'h03, idle cycle, valid 8'h03 → `stable`=1 after second valid; then valid 8'h01 → `stable`, `match` fall together; event_count=1.
- Break in ARM: valid 8'h03, valid 8'h01, valid 8'h03 → `stable` stays 0; FSM ends in ARM.
- Saturation/clear, CNT_W=2: produce 5 stable rising edges → event_count 1,2,3,3,3; then `clr` on the edge of a 6th rise → 0.
- Reset mid-run in STABLE → all outputs 0 next cycle; one following valid match with HOLD=2 → `stable` stays 0. Rebuild without `PTD_EVENT_COUNT_EN` → `event_count` constant 0.
